// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the shared-multiplier controller.
package mul_share_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LAUNCH,
    WAIT,
    DONE
  } state_e;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_MUL_LATENCY = 10;

  function automatic int product_w(input int width);
    return 2 * width + 1;
  endfunction

  localparam int PRODUCT_W = product_w(DEF_WIDTH);

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr_i wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         win_oh_o,
  output logic [$clog2(NUM_REQ)-1:0] win_idx_o,
  output logic                       any_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  int   j;
  logic found;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        win_oh_o[j] = 1'b1;
        win_idx_o   = IDX_W'(j);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one sequential multiplier among NUM_REQ requesters (round-robin).
// Optional MUL_SHARE_CTRL_STATS_EN adds op_count and busy outputs.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [2*WIDTH:0]           rsp_product,
  output logic                       mul_rst,
  output logic                       mul_start,
  output logic [WIDTH-1:0]           mul_multiplier,
  output logic [WIDTH-1:0]           mul_multiplicand,
`ifdef MUL_SHARE_CTRL_STATS_EN
  output logic [15:0]                op_count,
  output logic                       busy,
`endif
  input  logic [2*WIDTH:0]           mul_product
);
  localparam int PW    = product_w(WIDTH);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q, ptr_d, win_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, rsp_valid_q;
  logic [PW-1:0]      rsp_product_q;
  logic               mul_rst_q, mul_start_q;
  logic [WIDTH-1:0]   mula_q, mulb_q;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (arb_oh),
    .win_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  assign ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
  assign cnt_d = cnt_q + 1'b1;

  // gnt/rsp_valid are set on state entry so they are high exactly in CLEAR/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      mul_rst_q     <= 1'b0;
      mul_start_q   <= 1'b0;
      mula_q        <= '0;
      mulb_q        <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            win_q     <= arb_idx;
            mula_q    <= req_a[arb_idx*WIDTH +: WIDTH];
            mulb_q    <= req_b[arb_idx*WIDTH +: WIDTH];
            gnt_q     <= arb_oh;
            mul_rst_q <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          mul_rst_q   <= 1'b0;
          mul_start_q <= 1'b1;
          state_q     <= LAUNCH;
        end
        LAUNCH: begin
          mul_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_W'(MUL_LATENCY - 1)) begin
            rsp_product_q <= mul_product;
            rsp_valid_q   <= NUM_REQ'(1) << win_q;
            ptr_q         <= ptr_d;
            state_q       <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt              = gnt_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_product      = rsp_product_q;
  assign mul_rst          = mul_rst_q;
  assign mul_start        = mul_start_q;
  assign mul_multiplier   = mula_q;
  assign mul_multiplicand = mulb_q;

`ifdef MUL_SHARE_CTRL_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                op_count_q <= '0;
    else if (state_q == DONE)  op_count_q <= op_count_q + 16'd1;
  end

  assign op_count = op_count_q;
  assign busy     = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl with a behavioural multiplier attached.
module tb_mul_share_ctrl;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int L  = 10;
  localparam int PW = 2 * W + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_a, req_b;
  logic [N-1:0]    gnt, rsp_valid;
  logic [PW-1:0]   rsp_product, mul_product;
  logic            mul_rst, mul_start;
  logic [W-1:0]    mul_multiplier, mul_multiplicand;
`ifdef MUL_SHARE_CTRL_STATS_EN
  logic [15:0]     op_count;
  logic            busy;
`endif

  always #5 clk = ~clk;

  mul_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .MUL_LATENCY(L)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .req_a            (req_a),
    .req_b            (req_b),
    .gnt              (gnt),
    .rsp_valid        (rsp_valid),
    .rsp_product      (rsp_product),
    .mul_rst          (mul_rst),
    .mul_start        (mul_start),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
`ifdef MUL_SHARE_CTRL_STATS_EN
    .op_count         (op_count),
    .busy             (busy),
`endif
    .mul_product      (mul_product)
  );

  // Multiplier model: product appears L-1 edges after start is seen, cleared by rst.
  logic [W-1:0] ma, mb;
  int           mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_product <= '0; mcnt <= 0; ma <= '0; mb <= '0;
    end else if (mul_rst) begin
      mul_product <= '0; mcnt <= 0;
    end else if (mul_start) begin
      ma <= mul_multiplier; mb <= mul_multiplicand; mcnt <= L - 1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_product <= PW'(ma) * PW'(mb);
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [N*W-1:0] pk(input int v3, input int v2, input int v1, input int v0);
    return {W'(v3), W'(v2), W'(v1), W'(v0)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drives rq in an IDLE cycle c and checks the full transaction through c+13.
  task automatic do_op(input logic [N-1:0] rq, input logic [N-1:0] eg, input int ep,
                       input string nm);
    int wi;
    logic [W-1:0] ea, eb;
    wi = 0;
    for (int i = 0; i < N; i++) if (eg[i]) wi = i;
    ea  = req_a[wi*W +: W];
    eb  = req_b[wi*W +: W];
    req = rq;
    tick();
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_mulrst"}, 32'(mul_rst), 1);
    chk({nm, "_opa"}, 32'(mul_multiplier), 32'(ea));
`ifdef MUL_SHARE_CTRL_STATS_EN
    chk({nm, "_busy"}, 32'(busy), 1);
`endif
    req = '0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      chk({nm, "_novld"}, 32'(rsp_valid), 0);
      if (k == 2) begin
        chk({nm, "_start"}, 32'({mul_rst, mul_start}), 1);
        chk({nm, "_gntpulse"}, 32'(gnt), 0);
      end
      if (k == 3) chk({nm, "_startpulse"}, 32'(mul_start), 0);
`ifdef MUL_SHARE_CTRL_STATS_EN
      chk({nm, "_busy"}, 32'(busy), 1);
`endif
    end
    tick();
    chk({nm, "_vld"}, 32'(rsp_valid), 32'(eg));
    chk({nm, "_prod"}, 32'(rsp_product), ep);
    chk({nm, "_hold"}, 32'({mul_multiplier, mul_multiplicand}), 32'({ea, eb}));
  endtask

  typedef struct {
    logic [N-1:0]   rq;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N-1:0]   eg;
    int             ep;
  } vec_t;

  vec_t tbl[6];

  // Reference model bookkeeping for the random phase.
  logic [N-1:0]  eg_m[int];
  logic [N-1:0]  ev_m[int];
  int            ep_m[int];

  initial begin
    int gcount, rcount, last_g, base, free_at, ptr, w;
    logic [N-1:0] expg, expv;

    req = '0; req_a = '0; req_b = '0;
    do_reset();
    tick();
    chk("reset_outputs", 32'({gnt, rsp_valid, rsp_product, mul_rst, mul_start,
                              mul_multiplier, mul_multiplicand}), 0);
`ifdef MUL_SHARE_CTRL_STATS_EN
    chk("reset_stats", 32'({op_count, busy}), 0);
`endif

    tbl[0] = '{4'b0001, pk(0, 0, 0, 3),  pk(0, 0, 0, 6),   4'b0001, 18};
    tbl[1] = '{4'b0110, pk(0, 0, 15, 0), pk(0, 12, 15, 0), 4'b0010, 225};
    tbl[2] = '{4'b0100, pk(0, 0, 15, 0), pk(0, 12, 15, 0), 4'b0100, 0};
    tbl[3] = '{4'b1001, pk(5, 0, 0, 2),  pk(7, 0, 0, 2),   4'b1000, 35};
    tbl[4] = '{4'b1001, pk(5, 0, 0, 2),  pk(7, 0, 0, 2),   4'b0001, 4};
    tbl[5] = '{4'b1000, pk(15, 0, 0, 0), pk(1, 0, 0, 0),   4'b1000, 15};
    for (int r = 0; r < 6; r++) begin
      req_a = tbl[r].a;
      req_b = tbl[r].b;
      do_op(tbl[r].rq, tbl[r].eg, tbl[r].ep, "vec");
      tick();
    end
    tick();
    chk("prod_held", 32'({rsp_valid, rsp_product}), 15);

    // All four requesters hold req continuously.
    do_reset();
    tick();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = W'(2);
    end
    req = '1;
    gcount = 0; rcount = 0; last_g = 0; base = cyc;
    while (gcount < 5 && cyc - base < 80) begin
      tick();
      if (gnt != 0) begin
        chk("allreq_gnt", 32'(gnt), 32'(1 << (gcount % N)));
        if (gcount > 0) chk("allreq_gap", cyc - last_g, 14);
        last_g = cyc;
        gcount++;
      end
      if (rsp_valid != 0) begin
        chk("allreq_onehot", 32'($onehot(rsp_valid)), 1);
        chk("allreq_vld", 32'(rsp_valid), 32'(1 << (rcount % N)));
        chk("allreq_prod", 32'(rsp_product), ((rcount % N) + 1) * 2);
        rcount++;
      end
    end
    chk("allreq_count", gcount, 5);
    req = '0;
    for (int k = 0; k < 16; k++) tick();

    // Reset in the middle of WAIT abandons the operation.
    req_a = pk(0, 0, 0, 1);
    req_b = pk(0, 0, 0, 2);
    req   = 4'b0001;
    tick();
    chk("rstmid_gnt", 32'(gnt), 1);
    req = '0;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_outputs", 32'({gnt, rsp_valid, rsp_product, mul_rst, mul_start,
                               mul_multiplier, mul_multiplicand}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("rstmid_quiet", 32'({gnt, rsp_valid}), 0);
    end
    do_op(4'b0001, 4'b0001, 2, "rstmid_after");
    tick();

    // req[3] raised during another operation's WAIT.
    req_a = pk(4, 0, 0, 2);
    req_b = pk(4, 0, 0, 3);
    req   = 4'b0001;
    tick();
    chk("late_gnt0", 32'(gnt), 1);
    req = '0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (k == 4) req = 4'b1000;
      chk("late_nognt", 32'(gnt), 0);
    end
    tick();
    chk("late_vld0", 32'(rsp_valid), 1);
    chk("late_prod0", 32'(rsp_product), 6);
    tick();
    chk("late_idle", 32'(gnt), 0);
    tick();
    chk("late_gnt3", 32'(gnt), 32'(4'b1000));
    req = '0;
    for (int k = 2; k <= 12; k++) tick();
    tick();
    chk("late_vld3", 32'(rsp_valid), 32'(4'b1000));
    chk("late_prod3", 32'(rsp_product), 16);
    tick();

`ifdef MUL_SHARE_CTRL_STATS_EN
    do_reset();
    tick();
    req_a = pk(0, 0, 0, 0);
    req_b = pk(0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      chk("stats_idle_busy", 32'(busy), 0);
      do_op(4'b0010, 4'b0010, 0, "stats");
      tick();
    end
    chk("stats_count", 32'(op_count), 3);
    chk("stats_prod", 32'(rsp_product), 0);
    chk("stats_busy_end", 32'(busy), 0);
`endif

    // Randomized traffic against a transaction-level model.
    do_reset();
    eg_m.delete(); ev_m.delete(); ep_m.delete();
    free_at = cyc; ptr = 0;
    req_a = '0; req_b = '0;
    for (int c = 0; c < 820; c++) begin
      tick();
      expg = eg_m.exists(cyc) ? eg_m[cyc] : '0;
      expv = ev_m.exists(cyc) ? ev_m[cyc] : '0;
      chk("rand_gnt", 32'(gnt), 32'(expg));
      chk("rand_vld", 32'(rsp_valid), 32'(expv));
      if (expv != 0) chk("rand_prod", 32'(rsp_product), ep_m[cyc]);
      if (c < 800) begin
        for (int i = 0; i < N; i++) begin
          if (!req[i]) begin
            if ($urandom_range(2) == 0) begin
              req[i] = 1'b1;
              req_a[i*W +: W] = W'($urandom_range(15));
              req_b[i*W +: W] = W'($urandom_range(15));
            end
          end else if (gnt[i]) begin
            if ($urandom_range(3) != 0) req[i] = 1'b0;
            else begin
              req_a[i*W +: W] = W'($urandom_range(15));
              req_b[i*W +: W] = W'($urandom_range(15));
            end
          end else if ($urandom_range(15) == 0) begin
            req[i] = 1'b0;
          end
        end
      end else begin
        req = '0;
      end
      if (cyc >= free_at && req != 0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(ptr + k) % N]) w = (ptr + k) % N;
        eg_m[cyc + 1]     = N'(1 << w);
        ev_m[cyc + 3 + L] = N'(1 << w);
        ep_m[cyc + 3 + L] = int'(req_a[w*W +: W]) * int'(req_b[w*W +: W]);
        free_at = cyc + L + 4;
        ptr     = (w + 1) % N;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
